o_reg_tx: RTL
=============

# o_reg_tx

Output-side companion to the microprocessor's `i_pins` stimulus path. Watches the 4-bit `o_reg` port, captures every change of value into a small FIFO, and transmits each captured nibble off-chip as a framed, parity-protected serial word. Lets a board-level monitor or a second bench observe program output without probing `o_reg` in parallel.

## Interface

- `FIFO_DEPTH`, default 4: capture FIFO entries; power of two, 2 to 16.
- `BIT_CYCLES`, default 4: clocks per serial bit; 1 to 255.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0).
- `o_reg` in 4: microprocessor output register.
- `clear_overflow` in 1: synchronous, one-cycle clear of `overflow`.
- `tx_serial` out 1: serial line, idles high.
- `tx_busy` out 1: high while a frame is being sent.
- `fifo_count` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag, set when a capture is dropped.

## Operation

- Reset asserted: all state clears immediately.
  - `tx_serial`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0.
  - Internal `o_reg_q`=0, `o_reg_last`=0, FSM=IDLE, FIFO emptied.
- Capture:
  - `o_reg` is registered into `o_reg_q` every clock.
  - A capture event occurs when `o_reg_q` != `o_reg_last`.
  - On an event, `o_reg_q` is pushed and `o_reg_last` is updated on the same edge.
  - A value equal to the last captured value is never pushed. `o_reg` = 0 immediately after reset produces no event.
- FIFO:
  - First in, first out.
  - Push while full with no pop on the same edge: the push is dropped and `overflow` is set.
  - Push and pop on the same edge while full: both take effect and the count is unchanged.
  - `overflow` is cleared by `clear_overflow`. If a set and a clear land on the same edge, the set wins.
- Frame: 7 bits, each held for `BIT_CYCLES` clocks, in this order:
  - start bit (0);
  - data[0], data[1], data[2], data[3] (LSB first);
  - even parity bit, equal to XOR of the four data bits;
  - stop bit (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when the FIFO is non-empty. The pop and shift-register load happen on that same edge.
  - START→DATA after `BIT_CYCLES` clocks.
  - DATA→PARITY after 4×`BIT_CYCLES` clocks. A 2-bit bit index advances every `BIT_CYCLES` clocks.
  - PARITY→STOP after `BIT_CYCLES` clocks.
  - STOP→START directly if the FIFO is non-empty at the last stop cycle (pop on that edge, giving back-to-back frames). Otherwise STOP→IDLE.
- `tx_busy` is 1 in every state except IDLE.
- `tx_serial` is driven from a register (glitch-free) and is a function of state only.

## Timing

- Latency from a new `o_reg` value to the start bit, FSM idle and FIFO empty:
  - `o_reg` changes before edge k; `o_reg_q` updates at edge k.
  - Push at edge k+1; `fifo_count`=1 after k+1.
  - Pop and START at edge k+2; `tx_serial` falls after k+2 and `fifo_count` returns to 0.
- Frame length is exactly 7×`BIT_CYCLES` clocks.
- Back-to-back frames have no idle gap: the start bit of the next frame follows the last stop-bit clock directly.
- Changes of `o_reg` faster than one per clock are not resolved. Only the value sampled at each edge counts.
- Reset asserted mid-frame:
  - `tx_serial` returns to 1 asynchronously and the frame is abandoned.
  - After release, nothing is sent until a new capture event.
- `clear_overflow` affects only `overflow`. It never touches FIFO contents or the FSM.

## Test plan

- Single capture, defaults. After reset, `o_reg` goes 0→5.
  - `tx_serial` falls 2 clocks after `o_reg_q` updates.
  - Line carries 0,1,0,1,0,0,1, each bit held 4 clocks (28 clocks total).
  - `tx_busy` is high for exactly 28 clocks.
- Parity. Send 4'h7 and then 4'hF.
  - 4'h7 frame: parity bit 1.
  - 4'hF frame: parity bit 0.
  - The two frames are back-to-back with no idle clock between them.
- Overflow, `FIFO_DEPTH`=4. `o_reg` takes 1,2,3,4,5,6 on six consecutive clocks.
  - `fifo_count` peaks at 4 and `overflow`=1.
  - Frames 1,2,3,4,5 are sent in order; 6 is dropped.
- Repeated value. `o_reg` held at 9 for 50 clocks, then 9→3→9.
  - Exactly three frames are sent: 9, 3, 9.
- Clear versus set. Pulse `clear_overflow` on the same clock as a dropped push.
  - `overflow` stays 1.
  - A later lone `clear_overflow` pulse drives it to 0.
- Reset mid-frame. Assert `reset`=0 during the DATA bits of a frame for 1.5 clocks.
  - `tx_serial`=1, `fifo_count`=0 and `tx_busy`=0 immediately.
  - No further frames until `o_reg` changes.

Source files
------------

// File: rtl/o_reg_tx_if.sv
// o_reg_tx_if
// Bundles the o_reg_tx data-path and status signals.
//   o_reg          : microprocessor output register (into the transmitter)
//   clear_overflow : one-cycle clear of the sticky overflow flag
//   tx_serial      : framed serial line, idles high
//   tx_busy        : high while a frame is on the line
//   fifo_count     : capture FIFO occupancy
//   overflow       : sticky flag, a capture was dropped
// master = the side that drives o_reg (processor / bench),
// slave  = the transmitter.
interface o_reg_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    o_reg;
    logic          clear_overflow;
    logic          tx_serial;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output o_reg, clear_overflow,
        input  tx_serial, tx_busy, fifo_count, overflow
    );

    modport slave (
        input  o_reg, clear_overflow,
        output tx_serial, tx_busy, fifo_count, overflow
    );
endinterface

// File: rtl/o_reg_tx.sv
// o_reg_tx
// Watches the 4-bit o_reg port, captures every change of value into a small
// FIFO and sends each captured nibble as a 7-bit serial frame:
// start(0), d0..d3 (LSB first), even parity (XOR of data), stop(1).
// Each bit is held BIT_CYCLES clocks; frames may run back to back.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : o_reg_tx_if slave modport (o_reg, clear_overflow in;
//           tx_serial, tx_busy, fifo_count, overflow out)
module o_reg_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic      clk,
    input  logic      reset,
    o_reg_tx_if.slave bus
);
    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [7:0]    LAST_CYC   = 8'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // capture path
    logic [3:0]    o_reg_q;
    logic [3:0]    o_reg_last_q;

    // FIFO
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;

    // transmitter
    state_t        state_q;
    logic [7:0]    cyc_q;
    logic [1:0]    bit_idx_q;
    logic [3:0]    shreg_q;
    logic          parity_q;
    logic          tx_serial_q;
    logic          tx_busy_q;

    logic          capture;
    logic          fifo_empty;
    logic          fifo_full;
    logic          last_cyc;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign capture    = (o_reg_q != o_reg_last_q);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign last_cyc   = (cyc_q == LAST_CYC);

    // The transmitter takes a word when idle, or at the final stop-bit clock
    // so the next start bit follows with no idle gap.
    assign pop     = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && last_cyc));
    // A full FIFO still accepts a push if a pop frees a slot on the same edge.
    assign push_ok = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set beats clear when both land on the same edge.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_reg_q      <= '0;
            o_reg_last_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            o_reg_q <= bus.o_reg;
            // last value advances even when the push is dropped, so a held
            // value is never re-captured later
            if (capture) begin
                o_reg_last_q <= o_reg_q;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= o_reg_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q     <= START;
                        shreg_q     <= fifo_mem[rd_ptr_q];
                        parity_q    <= ^fifo_mem[rd_ptr_q];
                        cyc_q       <= '0;
                        tx_serial_q <= 1'b0;
                        tx_busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (last_cyc) begin
                        state_q     <= DATA;
                        cyc_q       <= '0;
                        bit_idx_q   <= '0;
                        tx_serial_q <= shreg_q[0];
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                DATA: begin
                    if (last_cyc) begin
                        cyc_q <= '0;
                        if (bit_idx_q == 2'd3) begin
                            state_q     <= PARITY;
                            tx_serial_q <= parity_q;
                        end else begin
                            // shift right so the next data bit is always at [1]
                            bit_idx_q   <= bit_idx_q + 2'd1;
                            shreg_q     <= {1'b0, shreg_q[3:1]};
                            tx_serial_q <= shreg_q[1];
                        end
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                PARITY: begin
                    if (last_cyc) begin
                        state_q     <= STOP;
                        cyc_q       <= '0;
                        tx_serial_q <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                STOP: begin
                    if (last_cyc) begin
                        cyc_q <= '0;
                        if (pop) begin
                            state_q     <= START;
                            shreg_q     <= fifo_mem[rd_ptr_q];
                            parity_q    <= ^fifo_mem[rd_ptr_q];
                            tx_serial_q <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            tx_serial_q <= 1'b1;
                            tx_busy_q   <= 1'b0;
                        end
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cyc_q       <= '0;
                    tx_serial_q <= 1'b1;
                    tx_busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_serial  = tx_serial_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule
